// File: rtl/alu_exec_pkg.sv
// Shared types for the execute stage: opcodes, flag bit positions, FSM states.
package alu_exec_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SHL = 3'd5,
    ALU_SHR = 3'd6,
    ALU_MUL = 3'd7
  } alu_op_e;

  // Bit positions inside the 4-bit flags vector {Z,N,C,V}.
  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_ITER = 2'd1,
    ST_DONE     = 2'd2
  } alu_state_e;

  // Pack individual flag bits into the architectural flags vector.
  function automatic logic [3:0] make_flags(input logic zero, input logic neg,
                                            input logic carry, input logic ovf);
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = zero;
    f[FLAG_N] = neg;
    f[FLAG_C] = carry;
    f[FLAG_V] = ovf;
    return f;
  endfunction

endpackage

// File: rtl/alu_exec_mul_unit.sv
// Shift-add multiplier: one partial product per step, W steps per multiply.
// product is the accumulator value *after* the current step, so the caller can
// capture the final product on the same edge as the last step.
module alu_mul_unit
  import alu_exec_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   a_in,
  input  logic [W-1:0]   b_in,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CW = $clog2(W) + 1;

  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] acc_step;

  // Next-state of the datapath: load clears, step does one shift-add iteration.
  always_comb begin
    acc_step = acc_q + (b_q[0] ? a_q : '0);
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    if (load) begin
      acc_d = '0;
      a_d   = {{W{1'b0}}, a_in};
      b_d   = b_in;
      cnt_d = '0;
    end else if (step) begin
      acc_d = acc_step;
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign done    = step && (cnt_q == CW'(W - 1));
  assign product = acc_step;

  // Datapath registers, cleared asynchronously so an aborted multiply leaves no trace.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      a_q   <= a_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute stage: single-cycle ALU ops, multi-cycle shift-add MUL, registered
// result with a one-cycle result_valid pulse and a {Z,N,C,V} flags register.
// Handshake: start is taken only when busy is low; a start seen while busy is
// dropped, and result_valid is high for exactly one cycle per accepted op.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  alu_op_e                   op,
  input  logic [DATA_BUS_WIDTH-1:0] operand_a,
  input  logic [DATA_BUS_WIDTH-1:0] operand_b,
  output logic                      busy,
  output logic [DATA_BUS_WIDTH-1:0] result,
  output logic                      result_valid,
  output logic [3:0]                flags,
  output alu_state_e                state_dbg
);

  localparam int W = DATA_BUS_WIDTH;

  alu_state_e     state_q, state_d;
  logic [W-1:0]   result_q, result_d;
  logic [3:0]     flags_q, flags_d;
  logic [W:0]     sum_ext;
  logic [W-1:0]   alu_res;
  logic           alu_c, alu_v;
  logic           mul_load, mul_step, mul_done;
  logic [2*W-1:0] mul_product;

  alu_mul_unit #(.W(W)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .load    (mul_load),
    .step    (mul_step),
    .a_in    (operand_a),
    .b_in    (operand_b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle ops; unknown encodings (and MUL, which never uses this path) fall to AND.
  always_comb begin
    sum_ext = '0;
    alu_res = operand_a & operand_b;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      ALU_ADD: begin
        sum_ext = {1'b0, operand_a} + {1'b0, operand_b};
        alu_res = sum_ext[W-1:0];
        alu_c   = sum_ext[W];
        alu_v   = (operand_a[W-1] == operand_b[W-1]) && (alu_res[W-1] != operand_a[W-1]);
      end
      ALU_SUB: begin
        sum_ext = {1'b0, operand_a} - {1'b0, operand_b};
        alu_res = sum_ext[W-1:0];
        alu_c   = sum_ext[W];
        alu_v   = (operand_a[W-1] != operand_b[W-1]) && (alu_res[W-1] != operand_a[W-1]);
      end
      ALU_OR:  alu_res = operand_a | operand_b;
      ALU_XOR: alu_res = operand_a ^ operand_b;
      ALU_SHL: begin
        alu_res = {operand_a[W-2:0], 1'b0};
        alu_c   = operand_a[W-1];
      end
      ALU_SHR: begin
        alu_res = {1'b0, operand_a[W-1:1]};
        alu_c   = operand_a[0];
      end
      default: alu_res = operand_a & operand_b;
    endcase
  end

  // FSM next-state plus result/flags capture and multiplier control.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    mul_load = 1'b0;
    mul_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op == ALU_MUL) begin
            mul_load = 1'b1;
            state_d  = ST_MUL_ITER;
          end else begin
            result_d = alu_res;
            flags_d  = make_flags(alu_res == '0, alu_res[W-1], alu_c, alu_v);
            state_d  = ST_DONE;
          end
        end
      end
      ST_MUL_ITER: begin
        mul_step = 1'b1;
        if (mul_done) begin
          result_d = mul_product[W-1:0];
          flags_d  = make_flags(mul_product[W-1:0] == '0, mul_product[W-1],
                                |mul_product[2*W-1:W], 1'b0);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, result and flags registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign result_valid = (state_q == ST_DONE);
  assign result       = result_q;
  assign flags        = flags_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_alu_exec.sv
// Testbench for alu_exec: directed cases with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_alu_exec;
  import alu_exec_pkg::*;

  localparam int W = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  alu_op_e    op;
  logic [W-1:0] operand_a, operand_b;
  logic       busy, result_valid;
  logic [W-1:0] result;
  logic [3:0] flags;
  alu_state_e state_dbg;

  int checks = 0;
  int errors = 0;

  // Model state
  int           left = 0;
  bit           cmp_en = 1'b0;
  logic [W-1:0] exp_res = '0;
  logic [3:0]   exp_flags = '0;
  logic [W-1:0] exp_q[$];
  logic [3:0]   exp_flag_q[$];

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  alu_exec #(.DATA_BUS_WIDTH(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .op           (op),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .flags        (flags),
    .state_dbg    (state_dbg)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: result and {Z,N,C,V} from plain integer arithmetic.
  function automatic void model_exec(input alu_op_e o, input logic [7:0] a, input logic [7:0] b,
                                     output logic [7:0] r, output logic [3:0] f);
    int ua = a;
    int ub = b;
    int sa = $signed(a);
    int sb = $signed(b);
    int full;
    bit c = 1'b0;
    bit v = 1'b0;
    case (o)
      ALU_ADD: begin full = ua + ub; c = (full > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      ALU_SUB: begin full = ua - ub; c = (ua < ub);    v = (sa - sb > 127) || (sa - sb < -128); end
      ALU_OR:  full = ua | ub;
      ALU_XOR: full = ua ^ ub;
      ALU_SHL: begin full = ua * 2; c = (ua >= 128); end
      ALU_SHR: begin full = ua / 2; c = (ua % 2) == 1; end
      ALU_MUL: begin full = ua * ub; c = (full > 255); end
      default: full = ua & ub;
    endcase
    r = full[7:0];
    f = {r == 8'h00, r[7], c, v};
  endfunction

  // Model: cycles remaining until idle; results queued at acceptance, shown at completion.
  always @(posedge clock or negedge reset) begin
    logic [7:0] pr;
    logic [3:0] pf;
    if (!reset) begin
      left      = 0;
      exp_res   = '0;
      exp_flags = '0;
      exp_q.delete();
      exp_flag_q.delete();
    end else if (left > 0) begin
      left--;
      if (left == 1 && exp_q.size() > 0) begin
        exp_res   = exp_q.pop_front();
        exp_flags = exp_flag_q.pop_front();
      end
    end else if (start) begin
      model_exec(op, operand_a, operand_b, pr, pf);
      exp_q.push_back(pr);
      exp_flag_q.push_back(pf);
      if (op == ALU_MUL) begin
        left = W + 1;
      end else begin
        left      = 1;
        exp_res   = exp_q.pop_front();
        exp_flags = exp_flag_q.pop_front();
      end
    end
  end

  // Scoreboard compare on every falling edge.
  always @(negedge clock) begin
    if (cmp_en) begin
      chk("cmp busy", {31'd0, busy}, {31'd0, left > 0});
      chk("cmp valid", {31'd0, result_valid}, {31'd0, left == 1});
      chk("cmp result", {24'd0, result}, {24'd0, exp_res});
      chk("cmp flags", {28'd0, flags}, {28'd0, exp_flags});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_op(input alu_op_e o, input logic [7:0] a, input logic [7:0] b,
                        input int exp_lat, input logic [7:0] r, input logic [3:0] f,
                        input string name);
    int lat;
    @(negedge clock);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(negedge clock);
    start = 1'b0;
    operand_a = W'($urandom);
    operand_b = W'($urandom);
    lat = 1;
    while (!result_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " result"}, {24'd0, result}, {24'd0, r});
    chk({name, " flags"}, {28'd0, flags}, {28'd0, f});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    reset = 1'b1; start = 1'b0; op = ALU_ADD; operand_a = '0; operand_b = '0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset valid", {31'd0, result_valid}, 32'd0);
    chk("reset result", {24'd0, result}, 32'd0);
    chk("reset flags", {28'd0, flags}, 32'd0);
    cmp_en = 1'b1;
    reset  = 1'b1;

    // 1. ADD overflow into sign bit
    run_op(ALU_ADD, 8'h7F, 8'h01, 1, 8'h80, 4'b0101, "t1 add");
    // 2. SUB to zero, then borrow
    run_op(ALU_SUB, 8'h05, 8'h05, 1, 8'h00, 4'b1000, "t2 sub zero");
    run_op(ALU_SUB, 8'h03, 8'h05, 1, 8'hFE, 4'b0110, "t2 sub borrow");
    // 3. MUL with and without high half
    run_op(ALU_MUL, 8'h12, 8'h10, 9, 8'h20, 4'b0010, "t3 mul hi");
    run_op(ALU_MUL, 8'h0F, 8'h11, 9, 8'hFF, 4'b0100, "t3 mul lo");

    // 4. starts while busy are dropped
    @(negedge clock);
    start = 1'b1; op = ALU_MUL; operand_a = 8'h12; operand_b = 8'h10;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
      start = (lat == 3 || lat == 5);
      op = ALU_ADD;
      operand_a = W'($urandom);
      operand_b = W'($urandom);
    end while (!result_valid && lat < 20);
    start = 1'b0;
    chk("t4 latency", lat, 9);
    chk("t4 result", {24'd0, result}, 32'h20);
    chk("t4 flags", {28'd0, flags}, 32'b0010);
    repeat (4) begin
      @(negedge clock);
      chk("t4 no second valid", {31'd0, result_valid}, 32'd0);
    end

    // 5. reset mid-multiply aborts it
    @(negedge clock);
    start = 1'b1; op = ALU_MUL; operand_a = 8'h0F; operand_b = 8'h11;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("t5 abort busy", {31'd0, busy}, 32'd0);
    chk("t5 abort result", {24'd0, result}, 32'd0);
    chk("t5 abort flags", {28'd0, flags}, 32'd0);
    chk("t5 abort valid", {31'd0, result_valid}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (10) begin
      @(negedge clock);
      chk("t5 no valid", {31'd0, result_valid}, 32'd0);
    end
    run_op(ALU_ADD, 8'h01, 8'h01, 1, 8'h02, 4'b0000, "t5 add");

    // 6. shifts and XOR
    run_op(ALU_SHR, 8'h81, 8'h00, 1, 8'h40, 4'b0010, "t6 shr");
    run_op(ALU_SHL, 8'h81, 8'h00, 1, 8'h02, 4'b0010, "t6 shl");
    run_op(ALU_XOR, 8'hAA, 8'hAA, 1, 8'h00, 4'b1000, "t6 xor");
    run_op(ALU_OR,  8'h0F, 8'h30, 1, 8'h3F, 4'b0000, "t6 or");
    run_op(ALU_AND, 8'hF0, 8'h3C, 1, 8'h30, 4'b0000, "t6 and");

    // Random phase: random starts (including while busy), ops and operands.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clock);
      start     = ($urandom_range(0, 2) == 0);
      op        = alu_op_e'($urandom_range(0, 7));
      operand_a = W'($urandom);
      operand_b = W'($urandom);
    end
    @(negedge clock);
    start = 1'b0;
    repeat (15) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
